fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Synchronous single-clock FIFO buffer with first-word-fall-through (FWFT) read data.
- Decouples a producer issuing single-cycle push strobes from a consumer issuing single-cycle pop strobes, at independent, irregular rates.
- Exposes full/empty status for flow control.
- Generic in depth and data width.

Parameters:
- FIFO_LENGTH, 4, number of storage entries (depth); any integer >= 2, power of two not required.
- DATA_WIDTH, 8, width of each data word in bits.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_push  input  1  write strobe; i_data is stored on the rising edge while asserted and accepted.
- i_pop  input  1  read strobe; the head word is removed on the rising edge while asserted and accepted.
- i_data  input  DATA_WIDTH  write data.
- o_data  output  DATA_WIDTH  head-of-queue word (FWFT).
- o_full  output  1  high when FIFO_LENGTH words are stored.
- o_empty  output  1  high when zero words are stored.

Behaviour:
- Storage: FIFO_LENGTH x DATA_WIDTH array, plus write pointer, read pointer and occupancy count (0..FIFO_LENGTH).
- Pointers advance modulo FIFO_LENGTH; wrap from FIFO_LENGTH-1 to 0 explicitly, since the depth need not be a power of two.
- Reset: when i_rst=1 at a rising edge, pointers and count clear to 0.
  - o_empty=1, o_full=0 from the next edge onward.
  - Memory contents are not cleared.
  - Reset has priority over push/pop and discards any stored words mid-operation.
- Flags: o_empty = (count==0) and o_full = (count==FIFO_LENGTH). Both are decoded from registered state, so they update in the cycle after the causing edge.
- Accepted push: i_push=1 and (not full, or i_pop accepted in the same cycle).
  - Writes i_data to mem[wr_ptr] and increments wr_ptr.
- Accepted pop: i_pop=1 and not empty.
  - Increments rd_ptr; the word is discarded.
- Count update: count +1 on push-only, -1 on pop-only, unchanged when both are accepted.
- o_data = mem[rd_ptr] combinationally (FWFT). The consumer samples o_data in the same cycle it asserts i_pop, before the edge.
  - o_data value is don't-care while o_empty=1, including after reset.
- Write latency: a word pushed at edge k appears on o_data after edge k when the FIFO was empty; o_empty falls after the same edge.
- Push when full without pop: ignored; contents, pointers and flags unchanged.
- Pop when empty: ignored; pointers unchanged, no underflow.
- Push+pop when full: both accepted; o_full stays 1 and the new word goes to the freed slot.
- Push+pop when empty: only the push is accepted (the pop is ignored); count becomes 1.
- Strobes may be held high for consecutive cycles; each cycle is an independent request.
- Data order is strictly preserved; no reordering or duplication.

Test Plan:
- Reset then idle: i_rst=1 for 5 cycles, then 0 -> o_empty=1, o_full=0; no flag activity without strobes.
- Single word: push 8'hA5 at one edge -> after the edge o_empty=0 and o_data=8'hA5; pop one cycle -> o_empty=1.
- Fill and overflow (depth 4): push 1,2,3,4 -> o_full=1 after the 4th edge; push 5 alone -> ignored; pops return 1,2,3,4 on o_data in order, then o_empty=1.
- Wrap-around: 256 pushes of values 0..255 interleaved with pops, random gaps of 0-9 cycles write side and 0-39 cycles read side, both waiting on o_full/o_empty -> every read equals the corresponding write in order; no mismatch.
- Simultaneous push+pop: when full holding 1..4, push 9 with pop -> o_data becomes 2 and o_full stays 1. When empty, push 7 with pop -> o_empty=0 and o_data=7.
- Reset mid-operation: 3 words stored, assert i_rst for one cycle -> o_empty=1, o_full=0; subsequent push 8'h3C is read back as 8'h3C.

Source files
------------

// File: rtl/fifo.sv
// fifo: single-clock first-word-fall-through FIFO with full/empty flags
module fifo #(
  parameter int FIFO_LENGTH = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int AW = $clog2(FIFO_LENGTH);
  localparam int CW = $clog2(FIFO_LENGTH + 1);
  logic [DATA_WIDTH-1:0] r_mem [FIFO_LENGTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == CW'(FIFO_LENGTH);
  assign o_data  = r_mem[r_rd];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr == AW'(FIFO_LENGTH - 1) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == AW'(FIFO_LENGTH - 1) ? '0 : r_rd + 1'b1;
      r_cnt <= w_push & ~w_pop ? r_cnt + 1'b1 : ~w_push & w_pop ? r_cnt - 1'b1 : r_cnt;
    end
  end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: scoreboard-based checks of the FWFT fifo at depth 4
module tb_fifo;
  logic i_clk = 0, i_rst = 0, i_push = 0, i_pop = 0;
  logic [7:0] i_data = '0, o_data;
  logic o_full, o_empty;
  int checks = 0, failures = 0;
  logic [7:0] q[$];

  fifo #(.FIFO_LENGTH(4), .DATA_WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(i_push), .i_pop(i_pop),
    .i_data(i_data), .o_data(o_data), .o_full(o_full), .o_empty(o_empty));

  always #5 i_clk = ~i_clk;

  task automatic step(input logic p, input logic po, input logic [7:0] d);
    logic ap, aw;
    ap = po && q.size() > 0;
    aw = p && (q.size() < 4 || ap);
    i_push = p; i_pop = po; i_data = d;
    @(posedge i_clk);
    if (ap) void'(q.pop_front());
    if (aw) q.push_back(d);
    @(negedge i_clk);
    i_push = 0; i_pop = 0;
  endtask

  task automatic test_reset;
    i_rst = 1;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_empty !== 1'b1 || o_full !== 1'b0) begin
        failures++; $display("FAIL reset_idle empty=%b full=%b want 1/0", o_empty, o_full);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_single;
    step(1, 0, 8'hA5);
    checks++;
    if (o_empty !== 1'b0 || o_data !== q[0]) begin
      failures++; $display("FAIL single_push empty=%b data=%h want 0/%h", o_empty, o_data, q[0]);
    end
    step(0, 1, 8'h00);
    checks++;
    if (o_empty !== 1'b1) begin
      failures++; $display("FAIL single_pop empty=%b want 1", o_empty);
    end
    step(0, 1, 8'h00);
    checks++;
    if (o_empty !== 1'b1 || o_full !== 1'b0) begin
      failures++; $display("FAIL pop_empty empty=%b full=%b want 1/0", o_empty, o_full);
    end
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 4; i++) step(1, 0, 8'(i));
    checks++;
    if (o_full !== 1'b1) begin
      failures++; $display("FAIL fill_full full=%b want 1", o_full);
    end
    step(1, 0, 8'd5);
    checks++;
    if (o_full !== 1'b1 || o_data !== 8'd1) begin
      failures++; $display("FAIL overflow full=%b data=%h want 1/01", o_full, o_data);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (o_data !== q[0] || o_data !== 8'(i)) begin
        failures++; $display("FAIL drain_%0d data=%h want %h", i, o_data, 8'(i));
      end
      step(0, 1, 8'h00);
    end
    checks++;
    if (o_empty !== 1'b1 || o_full !== 1'b0) begin
      failures++; $display("FAIL drained empty=%b full=%b want 1/0", o_empty, o_full);
    end
  endtask

  task automatic test_wrap;
    int wg, rg, wn, rn, cyc;
    logic p, po;
    logic [7:0] d;
    wg = $urandom_range(9); rg = $urandom_range(39); wn = 0; rn = 0; cyc = 0;
    while (rn < 256 && cyc < 30000) begin
      checks++;
      if (o_empty !== (q.size() == 0) || o_full !== (q.size() == 4)) begin
        failures++; $display("FAIL wrap_flags cyc=%0d empty=%b full=%b want %b/%b", cyc, o_empty, o_full, q.size() == 0, q.size() == 4);
      end
      p = wg == 0 && wn < 256 && !o_full;
      po = rg == 0 && !o_empty;
      d = 8'(wn);
      if (po) begin
        checks++;
        if (o_data !== 8'(rn)) begin
          failures++; $display("FAIL wrap_data read=%0d data=%h want %h", rn, o_data, 8'(rn));
        end
        rn++; rg = $urandom_range(39);
      end else if (rg > 0) rg--;
      if (p) begin
        wn++; wg = $urandom_range(9);
      end else if (wg > 0) wg--;
      step(p, po, d);
      cyc++;
    end
    checks++;
    if (rn != 256) begin
      failures++; $display("FAIL wrap_timeout reads=%0d want 256", rn);
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 1; i <= 4; i++) step(1, 0, 8'(i));
    step(1, 1, 8'd9);
    checks++;
    if (o_data !== 8'd2 || o_full !== 1'b1) begin
      failures++; $display("FAIL simul_full data=%h full=%b want 02/1", o_data, o_full);
    end
    while (q.size() > 0) begin
      checks++;
      if (o_data !== q[0]) begin
        failures++; $display("FAIL simul_drain data=%h want %h", o_data, q[0]);
      end
      step(0, 1, 8'h00);
    end
    step(1, 1, 8'd7);
    checks++;
    if (o_empty !== 1'b0 || o_data !== 8'd7 || o_full !== 1'b0) begin
      failures++; $display("FAIL simul_empty empty=%b data=%h want 0/07", o_empty, o_data);
    end
    step(0, 1, 8'h00);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h50 + i));
    i_rst = 1;
    @(posedge i_clk);
    q.delete();
    @(negedge i_clk);
    i_rst = 0;
    checks++;
    if (o_empty !== 1'b1 || o_full !== 1'b0) begin
      failures++; $display("FAIL reset_mid empty=%b full=%b want 1/0", o_empty, o_full);
    end
    step(1, 0, 8'h3C);
    checks++;
    if (o_empty !== 1'b0 || o_data !== 8'h3C) begin
      failures++; $display("FAIL reset_mid_push empty=%b data=%h want 0/3c", o_empty, o_data);
    end
    step(0, 1, 8'h00);
    checks++;
    if (o_empty !== 1'b1) begin
      failures++; $display("FAIL reset_mid_pop empty=%b want 1", o_empty);
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset;
    test_single;
    test_fill_overflow;
    test_wrap;
    test_simultaneous;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
